// File: rtl/biquad_coeff_ctrl.sv
// Shadow/active coefficient banks for a biquad cascade: commit runs a per-section stability check, then swaps on a sample strobe.
// Commit-to-done NUM_SECT+2 .. NUM_SECT+1+STROBE_TIMEOUT cycles; no backpressure, writes and commits while busy are dropped.
module biquad_coeff_ctrl #(
   parameter int NUM_SECT       = 4,
   parameter int COEFF_W        = 18,
   parameter int COEFF_FRAC     = 14,
   parameter int STROBE_TIMEOUT = 4096
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [$clog2(NUM_SECT)+2:0]   wr_addr,
   input  logic [COEFF_W-1:0]            wr_data,
   input  logic [$clog2(NUM_SECT)+2:0]   rd_addr,
   output logic [COEFF_W-1:0]            rd_data,
   input  logic                          commit,
   input  logic                          sample_strobe,
   output logic                          busy,
   output logic                          commit_done,
   output logic                          commit_err,
   output logic                          timeout_swap,
   output logic                          wr_err,
   output logic [NUM_SECT*COEFF_W-1:0]   b0_o,
   output logic [NUM_SECT*COEFF_W-1:0]   b1_o,
   output logic [NUM_SECT*COEFF_W-1:0]   b2_o,
   output logic [NUM_SECT*COEFF_W-1:0]   a1_o,
   output logic [NUM_SECT*COEFF_W-1:0]   a2_o
);

   localparam int AW = $clog2(NUM_SECT) + 3;
   localparam int SW = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1;
   localparam int TW = $clog2(STROBE_TIMEOUT + 1);
   localparam int CW = COEFF_W + 2;

   localparam int IDX_B0 = 0;
   localparam int IDX_B1 = 1;
   localparam int IDX_B2 = 2;
   localparam int IDX_A1 = 3;
   localparam int IDX_A2 = 4;

   localparam logic signed [COEFF_W-1:0] ONE_C = COEFF_W'(1 << COEFF_FRAC);
   localparam logic signed [CW-1:0]      ONE_W = CW'(1 << COEFF_FRAC);

   typedef logic signed [COEFF_W-1:0] coeff_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_ARMED,
      S_SWAP,
      S_FAIL
   } state_t;

   state_t            state_q, state_d;
   coeff_t            shadow_q [NUM_SECT][5];
   coeff_t            shadow_d [NUM_SECT][5];
   coeff_t            active_q [NUM_SECT][5];
   coeff_t            active_d [NUM_SECT][5];
   logic [SW-1:0]     sect_q, sect_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              tflag_q, tflag_d;
   logic              wr_err_q, wr_err_d;
   coeff_t            rd_data_q, rd_data_d;

   logic [AW-1:0]     wr_sect, rd_sect;
   logic [2:0]        wr_idx, rd_idx;
   logic              wr_ok, wr_take;
   coeff_t            chk_a1, chk_a2;
   logic signed [CW-1:0] a1_w, a2_w, a1_abs, a2_abs;
   logic              chk_pass, last_sect, tmo_hit;

   assign wr_sect = wr_addr >> 3;
   assign wr_idx  = wr_addr[2:0];
   assign rd_sect = rd_addr >> 3;
   assign rd_idx  = rd_addr[2:0];

   // Unmapped sections (non power-of-two NUM_SECT) are dropped like reserved idx values.
   assign wr_ok   = (wr_idx <= 3'd4) && (wr_sect < AW'(NUM_SECT));
   assign wr_take = wr_en && wr_ok && (state_q == S_IDLE);

   always_comb begin
      chk_a1 = '0;
      chk_a2 = '0;
      for (int s = 0; s < NUM_SECT; s++) begin
         if (sect_q == SW'(s)) begin
            chk_a1 = shadow_q[s][IDX_A1];
            chk_a2 = shadow_q[s][IDX_A2];
         end
      end
   end

   // Widened so |x| of the most negative coefficient and ONE + a2 cannot overflow.
   assign a1_w      = {{2{chk_a1[COEFF_W-1]}}, chk_a1};
   assign a2_w      = {{2{chk_a2[COEFF_W-1]}}, chk_a2};
   assign a1_abs    = a1_w[CW-1] ? -a1_w : a1_w;
   assign a2_abs    = a2_w[CW-1] ? -a2_w : a2_w;
   assign chk_pass  = (a2_abs < ONE_W) && (a1_abs < (ONE_W + a2_w));
   assign last_sect = (sect_q == SW'(NUM_SECT - 1));
   assign tmo_hit   = (tmo_q == TW'(STROBE_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (commit) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (!chk_pass)      state_d = S_FAIL;
            else if (last_sect) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (sample_strobe || tmo_hit) state_d = S_SWAP;
         end
         S_SWAP:  state_d = S_IDLE;
         S_FAIL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy         = (state_q != S_IDLE);
      commit_done  = (state_q == S_SWAP);
      timeout_swap = (state_q == S_SWAP) && tflag_q;
      commit_err   = (state_q == S_FAIL);
   end

   always_comb begin
      shadow_d = shadow_q;
      if (wr_take) begin
         for (int s = 0; s < NUM_SECT; s++) begin
            for (int i = 0; i < 5; i++) begin
               if ((wr_sect == AW'(s)) && (wr_idx == 3'(i))) shadow_d[s][i] = wr_data;
            end
         end
      end
   end

   // The active bank loads on the edge that ends SWAP, one edge after the strobe edge.
   always_comb begin
      active_d = active_q;
      if (state_q == S_SWAP) active_d = shadow_q;
   end

   always_comb begin
      sect_d    = (state_q == S_CHECK) ? sect_q + SW'(1) : '0;
      tmo_d     = (state_q == S_ARMED) ? tmo_q + TW'(1) : '0;
      tflag_d   = 1'b0;
      if (state_q == S_ARMED) tflag_d = tmo_hit && !sample_strobe;
      else if (state_q == S_SWAP) tflag_d = tflag_q;
      wr_err_d  = wr_en && !wr_take;
      rd_data_d = '0;
      for (int s = 0; s < NUM_SECT; s++) begin
         for (int i = 0; i < 5; i++) begin
            if ((rd_sect == AW'(s)) && (rd_idx == 3'(i))) rd_data_d = shadow_q[s][i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SECT; s++) begin
            for (int i = 0; i < 5; i++) begin
               shadow_q[s][i] <= (i == IDX_B0) ? ONE_C : '0;
               active_q[s][i] <= (i == IDX_B0) ? ONE_C : '0;
            end
         end
         sect_q    <= '0;
         tmo_q     <= '0;
         tflag_q   <= 1'b0;
         wr_err_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         sect_q    <= sect_d;
         tmo_q     <= tmo_d;
         tflag_q   <= tflag_d;
         wr_err_q  <= wr_err_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign wr_err  = wr_err_q;
   assign rd_data = rd_data_q;

   for (genvar s = 0; s < NUM_SECT; s++) begin : g_pack
      assign b0_o[s*COEFF_W +: COEFF_W] = active_q[s][IDX_B0];
      assign b1_o[s*COEFF_W +: COEFF_W] = active_q[s][IDX_B1];
      assign b2_o[s*COEFF_W +: COEFF_W] = active_q[s][IDX_B2];
      assign a1_o[s*COEFF_W +: COEFF_W] = active_q[s][IDX_A1];
      assign a2_o[s*COEFF_W +: COEFF_W] = active_q[s][IDX_A2];
   end

endmodule
